// File: rtl/wb_uart_tx.sv
// Wishbone classic console transmitter: byte FIFO feeding an 8N1 serialiser.
// Optional macro WB_UART_TX_IRQ_EN adds irq_o and the IRQEN register at address 3.
module wb_uart_tx #(
  parameter int unsigned FIFO_AW   = 3,
  parameter int unsigned DIV_RESET = 434
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
`ifdef WB_UART_TX_IRQ_EN
  output logic        irq_o,
`endif
  output logic        tx_o
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr, rptr, level;
  logic             full, empty, overflow;
  logic [15:0]      div, div_eff, cnt;
  logic [7:0]       shreg;
  logic [2:0]       bitcnt;
  logic             req, wr, push_req, push, pop, tick, tx_nxt;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:1]};

  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr       = req & wb_we_i & wb_sel_i[0];
  assign push_req = wr & (wb_adr_i[3:2] == 2'd0);

  // level never exceeds DEPTH, so its MSB alone marks full
  assign level = wptr - rptr;
  assign full  = level[FIFO_AW];
  assign empty = (level == '0);

  // pop uses the pre-edge empty flag, so a push into an empty FIFO is not popped that cycle
  assign pop  = (state == IDLE) & ~empty;
  assign push = push_req & (~full | pop);

  assign div_eff = (div < 16'd2) ? 16'd2 : div;
  assign tick    = (cnt == '0);

  always_ff @(posedge clock) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= wb_dat_i[7:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      div      <= 16'(DIV_RESET);
    end else begin
      if (push) wptr <= wptr + (FIFO_AW+1)'(1);
      if (pop)  rptr <= rptr + (FIFO_AW+1)'(1);
      if (push_req && !push)
        overflow <= 1'b1;
      else if (wr && wb_adr_i[3:2] == 2'd1 && wb_dat_i[3])
        overflow <= 1'b0;
      if (wr && wb_adr_i[3:2] == 2'd2) div <= wb_dat_i[15:0];
    end
  end

`ifdef WB_UART_TX_IRQ_EN
  logic [1:0] irqen;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irqen <= '0;
      irq_o <= 1'b0;
    end else begin
      if (wr && wb_adr_i[3:2] == 2'd3) irqen <= wb_dat_i[1:0];
      irq_o <= (empty & irqen[0]) | (overflow & irqen[1]);
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (wb_adr_i[3:2])
      2'd1: begin
        rdata[0]               = full;
        rdata[1]               = empty;
        rdata[2]               = (state != IDLE);
        rdata[3]               = overflow;
        rdata[8 +: FIFO_AW+1]  = level;
      end
      2'd2: rdata[15:0] = div;
`ifdef WB_UART_TX_IRQ_EN
      2'd3: rdata[1:0] = irqen;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req && !wb_we_i) ? rdata : '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_nxt    = 1'b1;
    case (state)
      IDLE:  if (!empty) state_nxt = START;
      START: begin
        tx_nxt = 1'b0;
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        tx_nxt = shreg[0];
        if (tick && bitcnt == 3'd7) state_nxt = STOP;
      end
      STOP:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt reloads from the live divisor only at bit boundaries, so DIV writes never cut a bit short
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      tx_o   <= 1'b1;
    end else begin
      tx_o <= tx_nxt;
      if (pop) begin
        shreg  <= mem[rptr[FIFO_AW-1:0]];
        cnt    <= div_eff - 16'd1;
        bitcnt <= '0;
      end else if (state != IDLE) begin
        if (tick) begin
          cnt <= div_eff - 16'd1;
          if (state == DATA) begin
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 3'd1;
          end
        end else begin
          cnt <= cnt - 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed and randomized bench for wb_uart_tx: bus accesses plus a sampled-line
// reference that rebuilds each expected 8N1 waveform from the bytes written.
`timescale 1ns/1ps
module tb_wb_uart_tx;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, tx_o;
`ifdef WB_UART_TX_IRQ_EN
  logic        irq_o;
`endif

  int unsigned errors = 0, checks = 0;
  logic        tx_hist[$];
  logic [7:0]  exp_q[$];
  int unsigned ack_wide = 0;
  logic        ack_prev = 1'b0;

  wb_uart_tx #(.FIFO_AW(3), .DIV_RESET(434)) dut (
    .clock(clock), .resetn(resetn),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
`ifdef WB_UART_TX_IRQ_EN
    .irq_o(irq_o),
`endif
    .tx_o(tx_o)
  );

  always #5 clock = ~clock;

  // one line sample per clock, taken just after the edge
  always begin
    @(posedge clock);
    #1;
    tx_hist.push_back(tx_o);
  end

  always @(negedge clock) begin
    if (wb_ack_o && ack_prev) ack_wide++;
    ack_prev = wb_ack_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wb(input logic we, input logic [3:0] adr, input logic [31:0] d,
                    output logic [31:0] r);
    int n = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = 4'hF; wb_dat_i = d;
    do begin
      @(negedge clock);
      n++;
    end while (!wb_ack_o && n < 8);
    r = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    check("ack_seen", 32'(wb_ack_o), 32'd1);
    check("ack_latency", (n <= 2) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] d);
    logic [31:0] r;
    wb(1'b1, adr, d, r);
  endtask

  task automatic rd(input logic [3:0] adr, output logic [31:0] r);
    wb(1'b0, adr, 32'h0, r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic smp(input int idx);
    if (idx < 0 || idx >= tx_hist.size()) return 1'bx;
    return tx_hist[idx];
  endfunction

  function automatic logic [31:0] status_word(input int lvl, input bit ovf, input bit busy);
    logic [31:0] w = '0;
    w[11:8] = 4'(lvl);
    w[3]    = ovf;
    w[2]    = busy;
    w[1]    = (lvl == 0);
    w[0]    = (lvl == 8);
    return w;
  endfunction

  // strict: first start bit exactly at 'from', one idle sample between frames
  task automatic check_frames(input string tag, input int from, input int bitlen, input bit strict);
    int s = from;
    for (int i = 0; i < exp_q.size(); i++) begin
      int st = s;
      bit bad = 1'b0;
      logic [9:0] fr;
      logic [7:0] got;
      while (st < tx_hist.size() && tx_hist[st] === 1'b1) st++;
      if (strict) check({tag, "_start"}, 32'(st), 32'((i == 0) ? from : s + 1));
      fr = {1'b1, exp_q[i], 1'b0};
      for (int b = 0; b < 10; b++)
        for (int k = 0; k < bitlen; k++)
          if (smp(st + b*bitlen + k) !== fr[b]) bad = 1'b1;
      for (int j = 0; j < 8; j++) got[j] = smp(st + (j+1)*bitlen + bitlen/2);
      check({tag, "_byte"}, 32'(got), 32'(exp_q[i]));
      check({tag, "_shape"}, 32'(bad), 32'd0);
      s = st + 10*bitlen;
    end
    begin
      bit bad = 1'b0;
      for (int idx = s; idx < tx_hist.size(); idx++)
        if (tx_hist[idx] !== 1'b1) bad = 1'b1;
      check({tag, "_idle"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    int mark, d, n, bl;

    repeat (3) @(negedge clock);
    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    resetn = 1'b1;
    idle(1);

    rd(4'h4, r); check("status_reset", r, status_word(0, 0, 0));
    rd(4'h8, r); check("div_reset", r, 32'd434);
    check("tx_idle", 32'(tx_o), 32'd1);

    // single frame, DIV=4
    wr(4'h8, 32'hFFFF_0004);
    rd(4'h8, r); check("div_upper_zero", r, 32'd4);
    wr(4'h0, 32'h55);
    mark = tx_hist.size();
    rd(4'h4, r); check("status_busy", r, status_word(0, 0, 1));
    rd(4'h0, r); check("data_reads_zero", r, 32'd0);
    idle(50);
    exp_q = {8'h55};
    check_frames("f55", mark + 1, 4, 1'b1);

    // back-to-back bytes, DIV=2
    wr(4'h8, 32'd2);
    wr(4'h0, 32'h41);
    mark = tx_hist.size();
    wr(4'h0, 32'h42);
    idle(60);
    exp_q = {8'h41, 8'h42};
    check_frames("fAB", mark + 1, 2, 1'b1);

    // DIV=0 clamps to 2-clock bits
    wr(4'h8, 32'd0);
    wr(4'h0, 32'hFF);
    mark = tx_hist.size();
    idle(40);
    exp_q = {8'hFF};
    check_frames("fclamp", mark + 1, 2, 1'b1);
    rd(4'h8, r); check("div_zero_readback", r, 32'd0);

    // overflow: 9 accepted (one popped at once), 10th dropped
    wr(4'h8, 32'd100);
    exp_q = {};
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      wr(4'h0, {24'h0, b});
      if (i == 0) mark = tx_hist.size();
      if (i < 9) exp_q.push_back(b);
    end
    rd(4'h4, r); check("status_overflow", r, status_word(8, 1, 1));
    wr(4'h4, 32'h8);
    rd(4'h4, r); check("status_ovf_clear", r, status_word(8, 0, 1));
    idle(9*1001 + 50);
    check_frames("fovf", mark + 1, 100, 1'b1);
    rd(4'h4, r); check("status_drained", r, status_word(0, 0, 0));

    // randomized rounds, at most 9 bytes so no overflow
    for (int rnd = 0; rnd < 4; rnd++) begin
      d  = $urandom_range(0, 6);
      bl = (d < 2) ? 2 : d;
      n  = $urandom_range(1, 9);
      wr(4'h8, 32'(d));
      mark = tx_hist.size();
      exp_q = {};
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        wr(4'h0, {24'h0, b});
        exp_q.push_back(b);
        idle($urandom_range(0, 15));
      end
      idle(n*(10*bl + 1) + 40);
      check_frames("frnd", mark, bl, 1'b0);
      rd(4'h4, r); check("status_rnd", r, status_word(0, 0, 0));
    end

`ifdef WB_UART_TX_IRQ_EN
    wr(4'hC, 32'h1);
    idle(2);
    check("irq_empty", 32'(irq_o), 32'd1);
    rd(4'hC, r); check("irqen_readback", r, 32'd1);
    wr(4'h0, 32'h5A);
    idle(1); check("irq_drop", 32'(irq_o), 32'd0);
    idle(1); check("irq_back", 32'(irq_o), 32'd1);
    idle(40);
`else
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'hC, r); check("reg3_reserved", r, 32'd0);
`endif

    // reset during a data bit discards the frame and the queued bytes
    wr(4'h8, 32'd20);
    wr(4'h0, 32'h00);
    wr(4'h0, 32'h11);
    wr(4'h0, 32'h22);
    idle(60);
    check("pre_rst_tx_low", 32'(tx_o), 32'd0);
    resetn = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx_o), 32'd1);
    idle(2);
    resetn = 1'b1;
    mark = tx_hist.size();
    idle(300);
    exp_q = {};
    check_frames("post_rst", mark, 20, 1'b0);
    rd(4'h4, r); check("status_after_rst", r, status_word(0, 0, 0));
    rd(4'h8, r); check("div_after_rst", r, 32'd434);

    check("ack_one_cycle", 32'(ack_wide), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
